// File: rtl/m_mac_pkg.sv
// Shared types and sizing for the coefficient store / MAC engine.
package m_mac_pkg;

  localparam int CGES_DEF = 7;
  localparam int DW_DEF   = 16;
  localparam int CW_DEF   = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mac_state_t;

  // Full product width plus enough headroom to sum n products without overflow.
  function automatic int ACC_W(input int dw, input int cw, input int n);
    return dw + cw + $clog2(n);
  endfunction

endpackage

// File: rtl/m_mac_datapath_if.sv
// Sequencer <-> MAC datapath bundle: coefficient write port, sample stream, completion.
interface m_mac_datapath_if #(
  parameter int CGES = m_mac_pkg::CGES_DEF,
  parameter int DW   = m_mac_pkg::DW_DEF,
  parameter int CW   = m_mac_pkg::CW_DEF
) ();
  import m_mac_pkg::*;

  localparam int AW = ACC_W(DW, CW, CGES);
  localparam int IW = $clog2(CGES);

  // Handshake: a coefficient write takes effect on any edge with wen high while the engine
  // is idle. sample_in is consumed on every RUN edge where sample_valid is high; there is
  // no back-pressure. fin is a level held until cal is seen low; result_valid pulses once.
  logic                 wen;
  logic [IW-1:0]        addr;
  logic signed [CW-1:0] coef_in;
  logic                 cal;
  logic signed [DW-1:0] sample_in;
  logic                 sample_valid;
  logic                 fin;
  logic signed [AW-1:0] result;
  logic                 result_valid;
  mac_state_t           dbg_state;

  modport master (
    output wen, addr, coef_in, cal, sample_in, sample_valid,
    input  fin, result, result_valid, dbg_state
  );

  modport slave (
    input  wen, addr, coef_in, cal, sample_in, sample_valid,
    output fin, result, result_valid, dbg_state
  );

endinterface

// File: rtl/m_coef_rf.sv
// Coefficient register file: one guarded write port, one combinational read port.
module m_coef_rf #(
  parameter int N      = 7,
  parameter int W      = 16,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem_q [N];

  // Addresses past the last tap are dropped; the sequencer's counter overshoots by one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else if (we && (int'(waddr) < N)) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/m_mac_datapath.sv
// MAC engine: captures coefficients while idle, then accumulates CGES sample*coef products.
module m_mac_datapath import m_mac_pkg::*; #(
  parameter int CGES = CGES_DEF,
  parameter int DW   = DW_DEF,
  parameter int CW   = CW_DEF,
  parameter int AW   = ACC_W(DW, CW, CGES)
) (
  input  logic         clk,
  input  logic         reset_n,
  m_mac_datapath_if.slave bus
);

  localparam int IW = $clog2(CGES);
  localparam int PW = DW + CW;
  localparam logic [IW-1:0] LAST_IDX = IW'(CGES - 1);

  mac_state_t           state_q, state_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic signed [AW-1:0] result_q, result_d;
  logic                 fin_q, fin_d;
  logic                 rv_q, rv_d;

  logic                 coef_we;
  logic [CW-1:0]        coef_rd;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] sum;

  assign coef_we = bus.wen && (state_q == S_IDLE);

  m_coef_rf #(.N(CGES), .W(CW)) u_coef_rf (
    .clk   (clk),
    .rst_n (reset_n),
    .we    (coef_we),
    .waddr (bus.addr),
    .wdata (bus.coef_in),
    .raddr (idx_q),
    .rdata (coef_rd)
  );

  assign prod = $signed(bus.sample_in) * $signed(coef_rd);
  assign sum  = acc_q + {{(AW-PW){prod[PW-1]}}, prod};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      fin_q    <= 1'b0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      fin_q    <= fin_d;
      rv_q     <= rv_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    result_d = result_q;
    fin_d    = 1'b0;
    rv_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cal) begin
          state_d = S_RUN;
          acc_d   = '0;
          idx_d   = '0;
        end
      end
      S_RUN: begin
        // Dropping cal mid-run abandons the sum; result keeps the last completed value.
        if (!bus.cal) begin
          state_d = S_IDLE;
        end else if (bus.sample_valid) begin
          if (idx_q == LAST_IDX) begin
            state_d  = S_DONE;
            result_d = sum;
            rv_d     = 1'b1;
            fin_d    = 1'b1;
          end else begin
            acc_d = sum;
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_DONE: begin
        if (bus.cal) begin
          fin_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.fin          = fin_q;
  assign bus.result       = result_q;
  assign bus.result_valid = rv_q;
  assign bus.dbg_state    = state_q;

endmodule
